// File: rtl/pll_lock_supervisor.sv
// Video PLL lock supervisor: sequences the PLL reset, qualifies lock stability,
// and holds the video domain in reset until lock has been continuously stable.
module pll_lock_supervisor #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 65536,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 500000,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned CNT_W               = 20
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       soft_reset,
  output logic       pll_rst,
  output logic       video_rst_n,
  output logic       pll_ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [7:0] lock_lost_cnt
);

  localparam int unsigned RETRY_W = 4;
  localparam int unsigned LOST_W  = 8;

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);
  localparam logic [LOST_W-1:0]  LOST_MAX     = {LOST_W{1'b1}};

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [RETRY_W-1:0]  retry_d;
  logic [RETRY_W-1:0]  retry_inc;
  logic [LOST_W-1:0]   lost_d;
  logic                sync_meta;
  logic                locked_s;
  logic                pll_rst_d;
  logic                video_rst_n_d;
  logic                pll_ready_d;
  logic                fail_d;

  // State, counters, synchronizer and registered output decode
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RST_PLL;
      cnt_q         <= '0;
      retry_cnt     <= '0;
      lock_lost_cnt <= '0;
      sync_meta     <= 1'b0;
      locked_s      <= 1'b0;
      pll_rst       <= 1'b1;
      video_rst_n   <= 1'b0;
      pll_ready     <= 1'b0;
      fail          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      retry_cnt     <= retry_d;
      lock_lost_cnt <= lost_d;
      sync_meta     <= pll_locked;
      locked_s      <= sync_meta;
      pll_rst       <= pll_rst_d;
      video_rst_n   <= video_rst_n_d;
      pll_ready     <= pll_ready_d;
      fail          <= fail_d;
    end
  end

  // Next-state, counter and output decode
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    retry_d       = retry_cnt;
    lost_d        = lock_lost_cnt;
    retry_inc     = retry_cnt + RETRY_W'(1);
    pll_rst_d     = 1'b0;
    video_rst_n_d = 1'b0;
    pll_ready_d   = 1'b0;
    fail_d        = 1'b0;

    unique case (state_q)
      ST_RST_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          retry_d = retry_inc;
          cnt_d   = '0;
          state_d = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_RST_PLL;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_STABLE: begin
        // A drop restarts qualification without counting as a timeout
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (!locked_s) begin
          lost_d  = (lock_lost_cnt == LOST_MAX) ? LOST_MAX : lock_lost_cnt + LOST_W'(1);
          state_d = ST_RST_PLL;
          cnt_d   = '0;
        end
      end
      ST_FAIL: begin
        state_d = ST_FAIL;
      end
      default: begin
        state_d = ST_RST_PLL;
        cnt_d   = '0;
      end
    endcase

    // Soft reset overrides any transition; the lock-loss count survives it
    if (soft_reset) begin
      state_d = ST_RST_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end

    pll_rst_d     = (state_d == ST_RST_PLL);
    video_rst_n_d = (state_d == ST_RUN);
    pll_ready_d   = (state_d == ST_RUN);
    fail_d        = (state_d == ST_FAIL);
  end

endmodule
